sr_excitation_driver: RTL and testbench
=======================================

# sr_excitation_driver

Drives a WIDTH-bit bank of posedge SR flip-flops to a requested target value by generating S/R excitation from the SR excitation table. Accepts a target over a valid/ready handshake, issues one excitation cycle, checks the bank's Q feedback and retries on mismatch. It is the controlling end of the SR flip-flop interface: it owns S and R and never drives the illegal S=R=1 combination.

## Interface
- WIDTH, 8, number of SR flip-flops driven (≥1)
- MAX_RETRY, 3, extra excitation attempts after a failed check (0 = no retry)

- clk  in  1  clock; all state and outputs update on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  target request valid
- req_ready  out  1  driver can accept a request (high only in IDLE)
- req_data  in  WIDTH  requested target Q value
- q_fb  in  WIDTH  Q outputs fed back from the SR bank
- S  out  WIDTH  set excitation to bank, registered
- R  out  WIDTH  reset excitation to bank, registered
- busy  out  1  high while a request is in progress (DRIVE or CHECK)
- done  out  1  one-cycle pulse when a request completes
- err  out  1  one-cycle pulse coincident with done when the target was not reached

## Operation
- States: IDLE, DRIVE, CHECK. Encoding is free.
- Reset (async, immediate): state=IDLE, S=0, R=0, done=0, err=0, busy=0, retry count=0, target register=0. req_ready=1 whenever state is IDLE, including during reset.
- Excitation function, per bit i, from target t and feedback q:
  - S[i] = t[i] & ~q[i] (0→1 transition: set)
  - R[i] = ~t[i] & q[i] (1→0 transition: reset)
  - bits already equal get S=R=0 (hold)
  - S & R is 0 in every cycle. This is a hard invariant.
- IDLE: on req_valid & req_ready:
  - latch req_data into the target register
  - load S/R from excitation(req_data, q_fb)
  - clear the retry count
  - go to DRIVE
- DRIVE: lasts one cycle; the bank samples S/R at its end. Next edge: S=R=0, go to CHECK.
- CHECK: compare q_fb with the target register.
  - Equal: go to IDLE and pulse done.
  - Unequal and retry count < MAX_RETRY: reload S/R from excitation(target, q_fb), increment retry, go to DRIVE.
  - Unequal and retry count = MAX_RETRY: go to IDLE and pulse done and err together.
- Retry counter width is $clog2(MAX_RETRY+1), minimum 1 bit. It never wraps.
- A target equal to the current q_fb still runs the full sequence with S=R=0 and completes without err.
- req_valid outside IDLE is ignored; req_data is not sampled.

## Timing
- Request accepted at edge 0, the end of cycle 0.
- Cycle 1: state DRIVE, S/R valid, busy=1.
- Cycle 2: state CHECK, S=R=0, q_fb reflects the bank update.
- Cycle 3: state IDLE, done=1 (and err=1 if the target was missed), busy=0, req_ready=1.
- Nominal latency is 3 cycles from acceptance to done. Each retry adds 2 cycles; the worst case is 3+2·MAX_RETRY.
- Back-to-back requests: a new request can be accepted in the done cycle, so throughput is one request per 3 cycles.
- done and err are high for exactly one cycle and are cleared on the next edge.
- Reset asserted mid-operation: S/R go to 0 at once, no done or err is produced, and the in-flight request is dropped.

## Test plan
- Reset, then bank Q=0x00, request 0xA5. Required: S=0xA5, R=0x00 in cycle 1; S=R=0 in cycle 2; done=1, err=0 in cycle 3.
- Bank Q=0xF0, request 0x3C. Required: S=0x0C, R=0xC0 in DRIVE; done in cycle 3 with bank Q=0x3C; S&R=0 checked every cycle by assertion.
- Request equal to current Q (0x5A). Required: S=R=0 throughout; done at cycle 3, err=0.
- Bank model forces bit 0 stuck at 0, request 0x01, MAX_RETRY=3. Required: 4 DRIVE cycles with S=0x01; done and err pulse together at cycle 9; busy deasserts in that same cycle.
- rst_n pulled low during DRIVE with S=0xFF. Required: S=R=0 immediately, req_ready=1, no done. After release, a request of 0x00 completes normally.
- req_valid held high continuously with alternating data. Required: accepted only in IDLE cycles, one request per 3 cycles, data sampled only at acceptance.

Source files
------------

// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver: drives an SR flip-flop bank to a target via excitation, verifies Q and retries.
module sr_excitation_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] target, target_nx, s_nx, r_nx, src;
    logic [RW-1:0]    retry, retry_nx;
    logic             accept, hit, retry_left, reload, done_nx, err_nx;

    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign accept     = req_valid & req_ready;
    assign hit        = q_fb == target;
    assign retry_left = retry < RW'(MAX_RETRY);
    assign reload     = state == CHECK && !hit && retry_left;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? DRIVE : IDLE;
            DRIVE:   state_nx = CHECK;
            CHECK:   state_nx = reload ? DRIVE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // S and R come from disjoint masks of the same src/q_fb pair, so they can never overlap.
    always_comb begin
        src       = accept ? req_data : target;
        s_nx      = (accept || reload) ? (src & ~q_fb) : '0;
        r_nx      = (accept || reload) ? (~src & q_fb) : '0;
        target_nx = accept ? req_data : target;
        retry_nx  = accept ? '0 : reload ? retry + RW'(1) : retry;
        done_nx   = state == CHECK && (hit || !retry_left);
        err_nx    = state == CHECK && !hit && !retry_left;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            S      <= '0;
            R      <= '0;
            target <= '0;
            retry  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            S      <= s_nx;
            R      <= r_nx;
            target <= target_nx;
            retry  <= retry_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb_sr_excitation_driver: directed vectors against a behavioural SR bank model with stuck-at injection.
module tb_sr_excitation_driver;
    logic       clk = 0, rst_n = 0, req_valid = 0, preset_en = 0;
    logic [7:0] req_data = 0, preset_val = 0, stuck = 0, bank = 0;
    logic [7:0] S, R;
    logic       req_ready, busy, done, err;
    int         checks = 0, errors = 0;

    typedef struct {
        logic [7:0] q0;
        logic [7:0] tgt;
        logic [7:0] s;
        logic [7:0] r;
    } vec_t;

    sr_excitation_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .q_fb(bank), .S(S), .R(R),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bank <= preset_en ? preset_val : ((bank & ~R) | S) & ~stuck;

    always @(negedge clk) begin
        checks++;
        if ((S & R) != 0) begin
            errors++;
            $display("FAIL sr_overlap S=%h R=%h required S&R=00", S, R);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [7:0] v);
        preset_en = 1; preset_val = v;
        @(negedge clk);
        preset_en = 0;
    endtask

    task automatic run_vec(input vec_t v);
        preset(v.q0);
        req_valid = 1; req_data = v.tgt;
        @(negedge clk);
        req_valid = 0; req_data = ~v.tgt;
        chk("drive_S", S, v.s);
        chk("drive_R", R, v.r);
        chk("drive_busy", busy, 1);
        chk("drive_ready", req_ready, 0);
        @(negedge clk);
        chk("check_S", S, 0);
        chk("check_R", R, 0);
        chk("check_bank", bank, v.tgt);
        chk("check_done", done, 0);
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_err", err, 0);
        chk("fin_busy", busy, 0);
        chk("fin_ready", req_ready, 1);
        @(negedge clk);
        chk("done_cleared", done, 0);
    endtask

    initial begin
        vec_t       vecs[6];
        int         n, acc;
        logic [7:0] last_acc;
        vecs[0] = '{8'h00, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{8'hF0, 8'h3C, 8'h0C, 8'hC0};
        vecs[2] = '{8'h5A, 8'h5A, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{8'h0F, 8'hF0, 8'hF0, 8'h0F};
        vecs[5] = '{8'h81, 8'h18, 8'h18, 8'h81};

        repeat (2) @(negedge clk);
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // bit 0 stuck low: initial drive plus three retries, then done+err together
        stuck = 8'h01;
        preset(8'h00);
        req_valid = 1; req_data = 8'h01;
        n = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            req_valid = 0;
            if (S == 8'h01) n++;
            if (k % 2 == 1 && k < 9) chk("stuck_drive_S", S, 8'h01);
            if (k < 9) begin
                chk("stuck_done_low", done, 0);
                chk("stuck_busy", busy, 1);
            end else begin
                chk("stuck_done", done, 1);
                chk("stuck_err", err, 1);
                chk("stuck_busy_end", busy, 0);
            end
        end
        chk("stuck_drive_count", n, 4);
        stuck = 0;
        @(negedge clk);
        chk("stuck_err_cleared", err, 0);

        // reset in the middle of DRIVE
        preset(8'h00);
        req_valid = 1; req_data = 8'hFF;
        @(negedge clk);
        req_valid = 0;
        chk("mid_drive_S", S, 8'hFF);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_S", S, 0);
        chk("mid_rst_R", R, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
            chk("mid_rst_no_err", err, 0);
        end
        rst_n = 1;
        run_vec('{8'h00, 8'h00, 8'h00, 8'h00});

        // req_valid held high with data alternating every cycle
        preset(8'h00);
        acc = 0; last_acc = 0;
        for (int c = 0; c < 12; c++) begin
            chk("hold_ready", req_ready, (c % 3 == 0) ? 1 : 0);
            if (c > 0 && c % 3 == 0) begin
                chk("hold_done", done, 1);
                chk("hold_bank", bank, last_acc);
            end else chk("hold_no_done", done, 0);
            req_valid = 1;
            req_data = c[0] ? 8'hC3 : 8'h3C;
            if (req_ready) begin
                acc++;
                last_acc = req_data;
            end
            @(negedge clk);
        end
        req_valid = 0;
        chk("hold_last_done", done, 1);
        chk("hold_last_bank", bank, last_acc);
        chk("hold_accepts", acc, 4);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
